observer_scan_ctrl: RTL and testbench

- Sequencer for the debug observer datapath. Drives the observer's mode and register-select inputs in a fixed walk: PC, IR, ALU A, ALU B, ALU out, then R0..R(NUM_REGS-1).
- Waits for the selected data to settle, then captures it into a snapshot register for the board display.
- Advances on a manual step/back command or on a dwell timer (auto-scan).

---
 rtl/observer_scan_ctrl_pkg.sv | 23 ++
 rtl/obs_scan_map.sv | 46 ++++
 rtl/observer_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_observer_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/observer_scan_ctrl_pkg.sv
// Shared constants and types for the debug observer scan sequencer.
// Holds the observer mode/select encodings and the sequencer FSM state type.
package observer_scan_ctrl_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_W-1:0] ZERO_WORD = '0;

   localparam logic [2:0] OBS_MODE_PC  = 3'd0;
   localparam logic [2:0] OBS_MODE_IR  = 3'd1;
   localparam logic [2:0] OBS_MODE_ALU = 3'd2;
   localparam logic [2:0] OBS_MODE_REG = 3'd3;

   localparam logic [REG_ADDR_W-1:0] OBS_ALU_A = 5'd1;
   localparam logic [REG_ADDR_W-1:0] OBS_ALU_B = 5'd2;
   localparam logic [REG_ADDR_W-1:0] OBS_ALU_O = 5'd0;

   typedef enum logic {
      SETTLE = 1'b0,
      DWELL  = 1'b1
   } obs_scan_state_t;

endpackage

// File: rtl/obs_scan_map.sv
// Combinational decode of a scan entry index into observer mode and select.
// Indices past the last register entry decode to the PC view.
module obs_scan_map
   import observer_scan_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic [4:0]            index,
   output logic [2:0]            mode,
   output logic [REG_ADDR_W-1:0] sel
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS + 4);

   always_comb begin
      mode = OBS_MODE_PC;
      sel  = '0;
      case (index)
         5'd0: begin
            mode = OBS_MODE_PC;
         end
         5'd1: begin
            mode = OBS_MODE_IR;
         end
         5'd2: begin
            mode = OBS_MODE_ALU;
            sel  = OBS_ALU_A;
         end
         5'd3: begin
            mode = OBS_MODE_ALU;
            sel  = OBS_ALU_B;
         end
         5'd4: begin
            mode = OBS_MODE_ALU;
            sel  = OBS_ALU_O;
         end
         default: begin
            if (index <= LAST_IDX) begin
               mode = OBS_MODE_REG;
               sel  = index - 5'd5;
            end
         end
      endcase
   end

endmodule

// File: rtl/observer_scan_ctrl.sv
// Walks the observer through PC, IR, ALU A/B/out and R0..R(NUM_REGS-1), capturing each view.
// Define OBS_SCAN_EDGE_EN to treat step_i/back_i as levels with internal rising-edge detection.
module observer_scan_ctrl
   import observer_scan_ctrl_pkg::*;
#(
   parameter int          NUM_REGS      = 16,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned DWELL_CYCLES  = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  auto_en_i,
   input  logic                  step_i,
   input  logic                  back_i,
   input  logic                  freeze_i,
   input  logic [REG_W-1:0]      data_i,
   output logic [2:0]            mode_o,
   output logic [REG_ADDR_W-1:0] reg_sel_o,
   output logic [4:0]            index_o,
   output logic [REG_W-1:0]      snap_o,
   output logic                  snap_valid_o,
   output logic                  busy_o
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS + 4);

   obs_scan_state_t state_q, state_d;
   logic [31:0] settle_q, settle_d;
   logic [31:0] dwell_q, dwell_d;
   logic [4:0]  index_q, index_d;
   logic [2:0]  mode_q;
   logic [REG_ADDR_W-1:0] sel_q;
   logic [REG_W-1:0] snap_q;
   logic snap_valid_q;
   logic capture;
   logic step_cmd, back_cmd;
   logic man_fwd, man_bwd, auto_tick;
   logic [2:0] map_mode;
   logic [REG_ADDR_W-1:0] map_sel;

`ifdef OBS_SCAN_EDGE_EN
   logic step_q, back_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= 1'b0;
         back_q <= 1'b0;
      end else begin
         step_q <= step_i;
         back_q <= back_i;
      end
   end

   assign step_cmd = step_i & ~step_q;
   assign back_cmd = back_i & ~back_q;
`else
   assign step_cmd = step_i;
   assign back_cmd = back_i;
`endif

   assign man_fwd = step_cmd & ~back_cmd;
   assign man_bwd = back_cmd & ~step_cmd;

   // Map the next index so mode/select register on the same edge as the index.
   obs_scan_map #(.NUM_REGS(NUM_REGS)) u_map (
      .index (index_d),
      .mode  (map_mode),
      .sel   (map_sel)
   );

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      dwell_d   = dwell_q;
      index_d   = index_q;
      capture   = 1'b0;
      auto_tick = 1'b0;
      case (state_q)
         SETTLE: begin
            if (!freeze_i) begin
               if (settle_q == SETTLE_CYCLES) begin
                  capture = 1'b1;
                  state_d = DWELL;
                  dwell_d = '0;
               end else begin
                  settle_d = settle_q + 32'd1;
               end
            end
         end
         DWELL: begin
            if (!auto_en_i) begin
               dwell_d = '0;
            end else if (!freeze_i) begin
               if (dwell_q == DWELL_CYCLES - 1) begin
                  dwell_d   = '0;
                  auto_tick = 1'b1;
               end else begin
                  dwell_d = dwell_q + 32'd1;
               end
            end
            // Manual commands take precedence over the dwell timer.
            if (!freeze_i && (man_fwd || man_bwd || auto_tick)) begin
               if (man_bwd) begin
                  index_d = (index_q == 5'd0) ? LAST_IDX : index_q - 5'd1;
               end else begin
                  index_d = (index_q == LAST_IDX) ? 5'd0 : index_q + 5'd1;
               end
               state_d  = SETTLE;
               settle_d = '0;
               dwell_d  = '0;
            end
         end
         default: begin
            state_d = SETTLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SETTLE;
         settle_q     <= '0;
         dwell_q      <= '0;
         index_q      <= '0;
         mode_q       <= OBS_MODE_PC;
         sel_q        <= '0;
         snap_q       <= ZERO_WORD;
         snap_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         dwell_q      <= dwell_d;
         index_q      <= index_d;
         mode_q       <= map_mode;
         sel_q        <= map_sel;
         snap_valid_q <= capture;
         if (capture) begin
            snap_q <= data_i;
         end
      end
   end

   assign mode_o       = mode_q;
   assign reg_sel_o    = sel_q;
   assign index_o      = index_q;
   assign snap_o       = snap_q;
   assign snap_valid_o = snap_valid_q;
   assign busy_o       = (state_q == SETTLE);

endmodule

// File: tb/tb_observer_scan_ctrl.sv
// Directed bench for observer_scan_ctrl with hand-computed expectations.
module tb_observer_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        auto_en = 1'b0;
   logic        step = 1'b0;
   logic        back = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] data = 32'h0;
   logic [2:0]  mode_o;
   logic [4:0]  reg_sel_o;
   logic [4:0]  index_o;
   logic [31:0] snap_o;
   logic        snap_valid_o;
   logic        busy_o;

   int n_total = 0;
   int n_bad   = 0;
   int snap_cnt = 0;
   int base;

   observer_scan_ctrl #(
      .NUM_REGS      (16),
      .SETTLE_CYCLES (2),
      .DWELL_CYCLES  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .auto_en_i    (auto_en),
      .step_i       (step),
      .back_i       (back),
      .freeze_i     (freeze),
      .data_i       (data),
      .mode_o       (mode_o),
      .reg_sel_o    (reg_sel_o),
      .index_o      (index_o),
      .snap_o       (snap_o),
      .snap_valid_o (snap_valid_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (snap_valid_o === 1'b1) snap_cnt = snap_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_step();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic pulse_back();
      back = 1'b1;
      @(negedge clk);
      back = 1'b0;
   endtask

   logic [2:0] exp_mode [5] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
   logic [4:0] exp_sel  [5] = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd0};

   initial begin
      data = 32'hDEAD_BEEF;
      cyc(2);
      check("rst_index", 32'(index_o), 32'd0);
      check("rst_mode", 32'(mode_o), 32'd0);
      check("rst_sel", 32'(reg_sel_o), 32'd0);
      check("rst_snap", snap_o, 32'h0);
      check("rst_valid", 32'(snap_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd1);

      rst = 1'b0;
      cyc(2);
      check("boot_nocap", 32'(snap_valid_o), 32'd0);
      cyc(1);
      check("boot_valid", 32'(snap_valid_o), 32'd1);
      check("boot_snap", snap_o, 32'hDEAD_BEEF);
      cyc(1);
      check("boot_busy", 32'(busy_o), 32'd0);

      base = snap_cnt;
      for (int i = 0; i < 5; i++) begin
         data = 32'hA000_0000 + 32'(i);
         pulse_step();
         check("step_index", 32'(index_o), 32'(i + 1));
         check("step_mode", 32'(mode_o), 32'(exp_mode[i]));
         check("step_sel", 32'(reg_sel_o), 32'(exp_sel[i]));
         cyc(9);
         check("step_snap", snap_o, 32'hA000_0000 + 32'(i));
      end
      cyc(1);
      check("step_snap_count", 32'(snap_cnt - base), 32'd5);

      base = snap_cnt;
      step = 1'b1;
      back = 1'b1;
      cyc(1);
      step = 1'b0;
      back = 1'b0;
      cyc(6);
      check("both_index", 32'(index_o), 32'd5);
      check("both_nosnap", 32'(snap_cnt - base), 32'd0);

      pulse_step();
      check("settle_busy", 32'(busy_o), 32'd1);
      pulse_step();
      cyc(8);
      check("settle_ignored", 32'(index_o), 32'd6);

      pulse_step();
      cyc(8);
      pulse_step();
      cyc(8);
      pulse_step();
      check("pre_rst_index", 32'(index_o), 32'd9);
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_index", 32'(index_o), 32'd0);
      check("arst_mode", 32'(mode_o), 32'd0);
      check("arst_sel", 32'(reg_sel_o), 32'd0);
      check("arst_snap", snap_o, 32'h0);
      check("arst_valid", 32'(snap_valid_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      data = 32'h1234_5678;
      cyc(3);
      check("reboot_valid", 32'(snap_valid_o), 32'd1);
      check("reboot_snap", snap_o, 32'h1234_5678);
      cyc(1);

      pulse_back();
      check("wrap_back_index", 32'(index_o), 32'd20);
      check("wrap_back_mode", 32'(mode_o), 32'd3);
      check("wrap_back_sel", 32'(reg_sel_o), 32'd15);
      cyc(6);
      pulse_step();
      check("wrap_fwd_index", 32'(index_o), 32'd0);
      check("wrap_fwd_mode", 32'(mode_o), 32'd0);
      check("wrap_fwd_sel", 32'(reg_sel_o), 32'd0);
      cyc(6);

      auto_en = 1'b1;
      cyc(3);
      check("auto_wait", 32'(index_o), 32'd0);
      cyc(1);
      check("auto_first", 32'(index_o), 32'd1);
      cyc(6);
      check("auto_hold", 32'(index_o), 32'd1);
      cyc(1);
      check("auto_period", 32'(index_o), 32'd2);
      check("auto_mode", 32'(mode_o), 32'd2);
      check("auto_sel", 32'(reg_sel_o), 32'd1);

      freeze = 1'b1;
      base = snap_cnt;
      cyc(20);
      check("freeze_index", 32'(index_o), 32'd2);
      check("freeze_nosnap", 32'(snap_cnt - base), 32'd0);
      check("freeze_busy", 32'(busy_o), 32'd1);
      freeze = 1'b0;
      auto_en = 1'b0;
      cyc(10);
      check("unfreeze_index", 32'(index_o), 32'd2);
      check("unfreeze_snap", 32'(snap_cnt - base), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
